// File: rtl/dir_key_event_encoder_pkg.sv
// rtl/dir_key_event_encoder_pkg.sv - scan codes, direction indices, FSM states and helpers
package kbd_pkg;

  localparam logic [8:0] SC_W      = 9'h01D;
  localparam logic [8:0] SC_S      = 9'h01B;
  localparam logic [8:0] SC_A      = 9'h01C;
  localparam logic [8:0] SC_D      = 9'h023;
  localparam logic [8:0] SC_LSHIFT = 9'h012;
  localparam logic [8:0] SC_RSHIFT = 9'h059;

  localparam logic [1:0] DIR_UP    = 2'd3;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_RIGHT = 2'd0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  function automatic logic [8:0] dir_code(input logic [1:0] idx);
    case (idx)
      DIR_UP:   return SC_W;
      DIR_DOWN: return SC_S;
      DIR_LEFT: return SC_A;
      default:  return SC_D;
    endcase
  endfunction

  // Highest changed bit wins; result is meaningless when diff is zero.
  function automatic logic [1:0] prio_sel(input logic [3:0] diff);
    if (diff[3])      return 2'd3;
    else if (diff[2]) return 2'd2;
    else if (diff[1]) return 2'd1;
    else              return 2'd0;
  endfunction

endpackage

// File: rtl/dir_key_event_encoder_if.sv
// rtl/dir_key_event_encoder_if.sv - direction request in, keyboard event stream out
interface dir_key_event_encoder_if;
  logic         en;
  logic [3:0]   dir_in;
  logic         been_ready;
  logic [8:0]   last_change;
  logic [511:0] key_down;
  logic         busy;

  modport master (
    output en, dir_in,
    input  been_ready, last_change, key_down, busy
  );

  modport slave (
    input  en, dir_in,
    output been_ready, last_change, key_down, busy
  );
endinterface

// File: rtl/dir_key_event_encoder.sv
// rtl/dir_key_event_encoder.sv - turns a direction bitmap into one-at-a-time make/break events
module dir_key_event_encoder
  import kbd_pkg::*;
#(
  parameter int EVENT_GAP = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  dir_key_event_encoder_if.slave  bus
);

  localparam logic [7:0] GAP_LOAD = 8'(EVENT_GAP - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] gap_cnt;
  logic [3:0] sent;
  logic [3:0] diff;
  logic [1:0] sel;
  logic       fire;

  assign diff = bus.dir_in ^ sent;
  assign sel  = prio_sel(diff);

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.en && (diff != 4'b0000)) begin
          fire    = 1'b1;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: state_d = ST_GAP;
      ST_GAP: begin
        if (gap_cnt == 8'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      gap_cnt         <= 8'd0;
      sent            <= 4'b0000;
      bus.been_ready  <= 1'b0;
      bus.last_change <= 9'h000;
    end else begin
      state_q        <= state_d;
      bus.been_ready <= fire;
      if (fire) begin
        bus.last_change <= dir_code(sel);
        sent[sel]       <= bus.dir_in[sel];
      end
      if (state_q == ST_STROBE)
        gap_cnt <= GAP_LOAD;
      else if ((state_q == ST_GAP) && (gap_cnt != 8'd0))
        gap_cnt <= gap_cnt - 8'd1;
    end
  end

  // key_down always mirrors sent, since both take dir_in[i] on the same event.
  always_comb begin
    bus.key_down         = '0;
    bus.key_down[SC_W]   = sent[DIR_UP];
    bus.key_down[SC_S]   = sent[DIR_DOWN];
    bus.key_down[SC_A]   = sent[DIR_LEFT];
    bus.key_down[SC_D]   = sent[DIR_RIGHT];
  end

  assign bus.busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dir_key_event_encoder.sv
// tb/tb_dir_key_event_encoder.sv - self-checking bench for dir_key_event_encoder
module tb_dir_key_event_encoder;

  localparam int EVENT_GAP = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  dir_key_event_encoder_if bus();

  dir_key_event_encoder #(.EVENT_GAP(EVENT_GAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] code_of(input int i);
    case (i)
      3:       return 9'h01D;
      2:       return 9'h01B;
      1:       return 9'h01C;
      default: return 9'h023;
    endcase
  endfunction

  function automatic logic [511:0] kd_from(input logic [3:0] bits);
    logic [511:0] v;
    v = '0;
    for (int i = 0; i < 4; i++) v[code_of(i)] = bits[i];
    return v;
  endfunction

  function automatic int top_bit(input logic [3:0] d);
    for (int i = 3; i >= 0; i--) if (d[i]) return i;
    return 0;
  endfunction

  // Reference: an event may start only once the cooldown since the previous one has elapsed.
  logic [3:0] m_sent;
  int         m_wait;
  logic       m_br;
  logic [8:0] m_lc;

  always @(posedge clk) begin
    if (rst) begin
      m_sent <= 4'b0;
      m_wait <= 0;
      m_br   <= 1'b0;
      m_lc   <= 9'h000;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      m_br   <= 1'b0;
    end else if (bus.en && ((bus.dir_in ^ m_sent) != 4'b0)) begin
      m_sent[top_bit(bus.dir_in ^ m_sent)] <= bus.dir_in[top_bit(bus.dir_in ^ m_sent)];
      m_lc   <= code_of(top_bit(bus.dir_in ^ m_sent));
      m_br   <= 1'b1;
      m_wait <= EVENT_GAP + 1;
    end else begin
      m_br <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus.dir_in = 4'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  int         pulse_t[$];
  logic [8:0] pulse_c[$];

  task automatic run_collect(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      step();
      if (bus.been_ready) begin
        pulse_t.push_back(i);
        pulse_c.push_back(bus.last_change);
      end
    end
  endtask

  typedef struct {
    logic       r;
    logic       e;
    logic [3:0] d;
    logic       br;
    logic [8:0] lc;
    logic       bsy;
    logic [3:0] kd;
  } tv_t;

  function automatic tv_t mk(input logic r, input logic e, input logic [3:0] d, input logic br,
                             input logic [8:0] lc, input logic bsy, input logic [3:0] kd);
    tv_t t;
    t.r = r; t.e = e; t.d = d; t.br = br; t.lc = lc; t.bsy = bsy; t.kd = kd;
    return t;
  endfunction

  tv_t vec[17];

  logic [8:0] burst_codes[4];
  logic       prev_br;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.en = 1'b0;
    bus.dir_in = 4'b0;

    vec[0]  = mk(1, 0, 4'b0000, 0, 9'h000, 0, 4'b0000);
    vec[1]  = mk(0, 1, 4'b1000, 1, 9'h01D, 1, 4'b1000);
    vec[2]  = mk(0, 1, 4'b1000, 0, 9'h01D, 1, 4'b1000);
    vec[3]  = mk(0, 1, 4'b1000, 0, 9'h01D, 1, 4'b1000);
    vec[4]  = mk(0, 1, 4'b1000, 0, 9'h01D, 1, 4'b1000);
    vec[5]  = mk(0, 1, 4'b1000, 0, 9'h01D, 1, 4'b1000);
    vec[6]  = mk(0, 1, 4'b1000, 0, 9'h01D, 0, 4'b1000);
    vec[7]  = mk(0, 1, 4'b0000, 1, 9'h01D, 1, 4'b0000);
    vec[8]  = mk(0, 1, 4'b0000, 0, 9'h01D, 1, 4'b0000);
    vec[9]  = mk(0, 1, 4'b0000, 0, 9'h01D, 1, 4'b0000);
    vec[10] = mk(0, 1, 4'b0000, 0, 9'h01D, 1, 4'b0000);
    vec[11] = mk(0, 1, 4'b0000, 0, 9'h01D, 1, 4'b0000);
    vec[12] = mk(0, 1, 4'b0000, 0, 9'h01D, 0, 4'b0000);
    vec[13] = mk(0, 0, 4'b0010, 0, 9'h01D, 0, 4'b0000);
    vec[14] = mk(0, 0, 4'b0010, 0, 9'h01D, 0, 4'b0000);
    vec[15] = mk(0, 1, 4'b0010, 1, 9'h01C, 1, 4'b0010);
    vec[16] = mk(0, 1, 4'b0010, 0, 9'h01C, 1, 4'b0010);

    burst_codes[0] = 9'h01D;
    burst_codes[1] = 9'h01B;
    burst_codes[2] = 9'h01C;
    burst_codes[3] = 9'h023;

    for (int k = 0; k < 17; k++) begin
      rst = vec[k].r;
      bus.en = vec[k].e;
      bus.dir_in = vec[k].d;
      step();
      chk($sformatf("vec%0d_been_ready", k), 512'(bus.been_ready), 512'(vec[k].br));
      chk($sformatf("vec%0d_last_change", k), 512'(bus.last_change), 512'(vec[k].lc));
      chk($sformatf("vec%0d_busy", k), 512'(bus.busy), 512'(vec[k].bsy));
      chk($sformatf("vec%0d_key_down", k), bus.key_down, kd_from(vec[k].kd));
    end

    // All four keys pressed at once: priority order, fixed spacing.
    do_reset();
    pulse_t.delete();
    pulse_c.delete();
    bus.en = 1'b1;
    bus.dir_in = 4'b1111;
    run_collect(40);
    chk("burst_count", 512'(pulse_c.size()), 512'd4);
    for (int k = 0; k < 4 && k < pulse_c.size(); k++)
      chk($sformatf("burst_code%0d", k), 512'(pulse_c[k]), 512'(burst_codes[k]));
    for (int k = 1; k < 4 && k < pulse_t.size(); k++)
      chk($sformatf("burst_spacing%0d", k), 512'(pulse_t[k] - pulse_t[k-1]), 512'(EVENT_GAP + 2));
    chk("burst_popcount", 512'($countones(bus.key_down)), 512'd4);
    chk("burst_key_down", bus.key_down, kd_from(4'b1111));

    // D requested then withdrawn while W is still in its gap.
    do_reset();
    pulse_t.delete();
    pulse_c.delete();
    bus.en = 1'b1;
    bus.dir_in = 4'b1001;
    run_collect(2);
    bus.dir_in = 4'b1000;
    run_collect(20);
    chk("glitch_count", 512'(pulse_c.size()), 512'd1);
    if (pulse_c.size() > 0) chk("glitch_code", 512'(pulse_c[0]), 512'h01D);
    chk("glitch_key_down", bus.key_down, kd_from(4'b1000));

    // Reset while the first event of a burst is in STROBE.
    do_reset();
    bus.en = 1'b1;
    bus.dir_in = 4'b1111;
    step();
    chk("rst_mid_strobe_pre", 512'(bus.been_ready), 512'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_been_ready", 512'(bus.been_ready), 512'd0);
    chk("rst_mid_last_change", 512'(bus.last_change), 512'h000);
    chk("rst_mid_key_down", bus.key_down, 512'd0);
    chk("rst_mid_busy", 512'(bus.busy), 512'd0);
    pulse_t.delete();
    pulse_c.delete();
    run_collect(40);
    chk("rst_restart_count", 512'(pulse_c.size()), 512'd4);
    for (int k = 0; k < 4 && k < pulse_c.size(); k++)
      chk($sformatf("rst_restart_code%0d", k), 512'(pulse_c[k]), 512'(burst_codes[k]));

    // Random traffic against the reference model.
    do_reset();
    prev_br = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      bus.en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) bus.dir_in = 4'($urandom);
      step();
      chk($sformatf("rnd%0d_been_ready", i), 512'(bus.been_ready), 512'(m_br));
      chk($sformatf("rnd%0d_last_change", i), 512'(bus.last_change), 512'(m_lc));
      chk($sformatf("rnd%0d_busy", i), 512'(bus.busy), 512'(m_wait > 0));
      chk($sformatf("rnd%0d_key_down", i), bus.key_down, kd_from(m_sent));
      chk($sformatf("rnd%0d_no_b2b", i), 512'(prev_br & bus.been_ready), 512'd0);
      prev_br = bus.been_ready;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dir_key_event_encoder.md
# dir_key_event_encoder

Converts a 4-bit direction bitmap (bit3 up/W, bit2 down/S, bit1 left/A, bit0 right/D) into the keyboard event stream the direction decoder consumes: a one-cycle `been_ready` strobe, a 9-bit `last_change` scan code, and the 512-bit `key_down` vector. It sits in front of the direction decoder so that demo/autopilot logic or on-board buttons can drive the game exactly as a PS/2 keyboard would. It emits make events for newly set bits and break events for newly cleared bits, one event at a time, with a guaranteed idle gap between events.

## Interface
- `EVENT_GAP`, default 4: idle cycles between the end of one `been_ready` pulse and the next event evaluation; legal range 1..255.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: when high, new events may start; when low, no new event starts.
- `dir_in` input 4: requested direction bitmap, sampled live every cycle.
- `been_ready` output 1: one-cycle strobe marking a new event.
- `last_change` output 9: scan code of the latest event; `9'h01D` W, `9'h01B` S, `9'h01C` A, `9'h023` D.
- `key_down` output 512: pressed-key vector, indexed by scan code; only bits 0x1D, 0x1B, 0x1C and 0x23 can ever be 1.
- `busy` output 1: high when state is not IDLE.

## Operation
- Internal `sent[3:0]` holds the bitmap already communicated downstream. Reset value is 0, which matches the decoder's reset value of 0.
- `diff = dir_in ^ sent`. The highest set bit of `diff` has priority (bit3 > bit2 > bit1 > bit0).
- FSM states are IDLE, STROBE and GAP.
  - IDLE: if `en && diff != 0`, take the priority bit i. On the clock edge: `last_change <= CODE[i]`, `key_down[CODE[i]] <= dir_in[i]`, `sent[i] <= dir_in[i]`, `been_ready <= 1`, and the state goes to STROBE. Otherwise stay in IDLE.
  - STROBE: `been_ready <= 0`, gap counter `<= EVENT_GAP-1`, state goes to GAP.
  - GAP: decrement the counter; at 0 go to IDLE. `en` is ignored, so a started gap always completes.
- `dir_in` is never latched. A bit that toggles and returns before it is serviced produces no event (glitch collapse).
- Bits of `sent` other than the serviced bit are unchanged. `key_down` bits other than the four codes are held at 0.
- `last_change` and `key_down` hold their values between events.

## Timing
- Reset values: `been_ready` 0, `last_change` 9'h000, `key_down` all 0, `busy` 0, `sent` 0, state IDLE.
- Reset mid-event drops any pending and in-flight event. No break events are emitted for keys that were held.
- Latency: if the condition holds in IDLE at cycle t, `been_ready` is high in cycle t+1, and `last_change`/`key_down` are valid in that same cycle.
- `been_ready` is exactly one cycle wide and is never asserted in back-to-back cycles.
- Minimum event period is EVENT_GAP+2 cycles (IDLE, STROBE, GAP×EVENT_GAP).
- Simultaneous multi-bit change: events are emitted in priority order, one per period.
- Toggling `en` low during STROBE or GAP has no effect until the machine returns to IDLE.

## Structure
- Shared package `kbd_pkg` holds:
  - the scan-code constants (W/S/A/D, plus left/right shift for future use);
  - the direction bit indices;
  - the FSM state enum;
  - a function mapping a direction index to its scan code.
- No sub-module is needed. The priority select is a function in the package, and the gap counter is an 8-bit register inside the block.

## Test plan
- Reset, then `en=1`, `dir_in` 0→4'b1000: `been_ready` pulses one cycle after the change with `last_change=9'h01D` and `key_down[9'h01D]=1`. No further pulses.
- From `sent=4'b1000`, `dir_in` → 4'b0000: one pulse with `last_change=9'h01D` and `key_down[9'h01D]=0`.
- `dir_in` 0→4'b1111 with EVENT_GAP=4: four pulses exactly 6 cycles apart with codes 1D, 1B, 1C, 23 in that order. At the end `key_down` has exactly 4 bits set.
- While the W event is in GAP, `dir_in` goes 4'b1001→4'b1000 before D is serviced: no D event is emitted.
- `en=0` with `dir_in`=4'b0010: no pulse and `busy=0`. Raising `en`: pulse with code 1C on the next cycle.
- Assert `rst` one cycle during STROBE of a 4'b1111 burst: all outputs return to reset values the next cycle. Re-evaluation then restarts from `sent=0` and emits all four events again.
